// File: rtl/nt_pkg.sv
// nt_pkg: neurotransmitter channel indices and quantised-level codes
package nt_pkg;
  localparam int NUM_NT = 5;
  localparam int CH_CORT = 0;
  localparam int CH_DOP = 1;
  localparam int CH_GABA = 2;
  localparam int CH_NE = 3;
  localparam int CH_SER = 4;
  localparam logic [1:0] LVL_LOW = 2'b00;
  localparam logic [1:0] LVL_MID_LOW = 2'b01;
  localparam logic [1:0] LVL_MID_HIGH = 2'b10;
  localparam logic [1:0] LVL_HIGH = 2'b11;
endpackage

// File: rtl/nt_level_channel.sv
// nt_level_channel: one saturating neurotransmitter level with idle-driven homeostatic drift
module nt_level_channel #(
  parameter int LEVEL_W = 6,
  parameter int FAST_STEP = 2,
  parameter int DECAY_DIV = 64,
  parameter int BASELINE = 2 ** (LEVEL_W - 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               slow_stb,
  input  logic               inc,
  input  logic               dec,
  input  logic               fast,
  output logic [LEVEL_W-1:0] level
);
  localparam int IW = $clog2(DECAY_DIV);
  localparam logic [LEVEL_W-1:0] BASE = LEVEL_W'(BASELINE);
  logic [IW-1:0] idle;
  logic [LEVEL_W:0] step, up, dn;
  logic [LEVEL_W-1:0] nxt;
  logic act, decay;
  // Requests win over decay; the extra top bit of up/dn flags overflow/underflow for clamping
  always_comb begin
    act = inc | dec;
    step = fast ? (LEVEL_W + 1)'(FAST_STEP) : {{LEVEL_W{1'b0}}, slow_stb};
    up = {1'b0, level} + step;
    dn = {1'b0, level} - step;
    decay = idle == IW'(DECAY_DIV - 1);
    nxt = inc && dec ? level
        : inc ? (up[LEVEL_W] ? '1 : up[LEVEL_W-1:0])
        : dec ? (dn[LEVEL_W] ? '0 : dn[LEVEL_W-1:0])
        : !decay ? level
        : level > BASE ? level - 1'b1
        : level < BASE ? level + 1'b1 : level;
  end
  // Level and idle counter advance only on simulation ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= BASE;
      idle <= '0;
    end else if (en) begin
      level <= nxt;
      idle <= act || decay ? '0 : idle + 1'b1;
    end
  end
endmodule

// File: rtl/neurotransmitter_level_bank.sv
// neurotransmitter_level_bank: bank of per-channel levels sharing one slow-rate prescaler
module neurotransmitter_level_bank
  import nt_pkg::*;
#(
  parameter int NUM_CH = NUM_NT,
  parameter int LEVEL_W = 6,
  parameter int SLOW_DIV = 16,
  parameter int FAST_STEP = 2,
  parameter int DECAY_DIV = 64,
  parameter int BASELINE = 2 ** (LEVEL_W - 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         inc,
  input  logic [NUM_CH-1:0]         dec,
  input  logic [NUM_CH-1:0]         fast,
  output logic [NUM_CH*LEVEL_W-1:0] level,
  output logic [NUM_CH*2-1:0]       level_q,
  output logic [NUM_CH-1:0]         sat_hi,
  output logic [NUM_CH-1:0]         sat_lo
);
  localparam int SW = $clog2(SLOW_DIV);
  logic [SW-1:0] cnt;
  logic slow_stb;
  assign slow_stb = en && cnt == SW'(SLOW_DIV - 1);
  // Shared prescaler: frozen while en is low, wraps at SLOW_DIV-1
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= slow_stb ? '0 : cnt + 1'b1;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nt_level_channel #(
      .LEVEL_W(LEVEL_W),
      .FAST_STEP(FAST_STEP),
      .DECAY_DIV(DECAY_DIV),
      .BASELINE(BASELINE)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en),
      .slow_stb(slow_stb),
      .inc(inc[i]),
      .dec(dec[i]),
      .fast(fast[i]),
      .level(level[i*LEVEL_W +: LEVEL_W])
    );
    assign level_q[2*i +: 2] = level[i*LEVEL_W + LEVEL_W - 2 +: 2];
    assign sat_hi[i] = &level[i*LEVEL_W +: LEVEL_W];
    assign sat_lo[i] = ~|level[i*LEVEL_W +: LEVEL_W];
  end
endmodule
